// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb blast engine: grid geometry, cell and fuse
// codes, scanner states, flame directions and the row/col -> index helper.
package bomb_pkg;

    localparam int GRID  = 10;
    localparam int NCELL = GRID * GRID;
    localparam int IDX_W = 7;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'd0;
    localparam cell_t CELL_WALL  = 2'd1;
    localparam cell_t CELL_PA    = 2'd2;
    localparam cell_t CELL_PB    = 2'd3;

    localparam logic [1:0] FUSE_NONE = 2'd0;
    localparam logic [1:0] FUSE_NEW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        DECAY,
        BLAST,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return IDX_W'(row) * IDX_W'(GRID) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/flame_walker.sv
// Flame ray walker: remembers the detonation origin, the current direction
// (up, down, left, right in that order) and the step count, and presents the
// cell the ray is about to enter. Wall and bomb handling stay in the parent.
module flame_walker
    import bomb_pkg::*;
#(
    parameter int RANGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [3:0]       row_i,
    input  logic [3:0]       col_i,
    input  logic             advance_i,
    input  logic             turn_i,
    output logic [IDX_W-1:0] cell_o,
    output logic             off_grid_o,
    output logic             ray_end_o,
    output logic             last_dir_o
);

    localparam logic signed [4:0] GRID_S = 5'(GRID);

    logic [3:0]        row_q;
    logic [3:0]        col_q;
    dir_e              dir_q;
    logic [3:0]        step_q;
    logic signed [4:0] row_s;
    logic signed [4:0] col_s;
    logic              off_grid;

    // Origin/direction/step register: load on a new detonation, turn at ray end, else advance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            dir_q  <= DIR_UP;
            step_q <= 4'd1;
        end else if (load_i) begin
            row_q  <= row_i;
            col_q  <= col_i;
            dir_q  <= DIR_UP;
            step_q <= 4'd1;
        end else if (turn_i) begin
            dir_q  <= dir_e'(dir_q + 2'd1);
            step_q <= 4'd1;
        end else if (advance_i) begin
            step_q <= step_q + 4'd1;
        end
    end

    // Signed target coordinate so stepping past row/col 0 is seen as off-grid, never a wrap.
    always_comb begin
        // NOTE: every output gets a value before the case so no path can infer a latch.
        row_s = $signed({1'b0, row_q});
        col_s = $signed({1'b0, col_q});
        case (dir_q)
            DIR_UP:    row_s = row_s - $signed({1'b0, step_q});
            DIR_DOWN:  row_s = row_s + $signed({1'b0, step_q});
            DIR_LEFT:  col_s = col_s - $signed({1'b0, step_q});
            default:   col_s = col_s + $signed({1'b0, step_q});
        endcase
        off_grid   = (row_s < 0) || (row_s >= GRID_S) || (col_s < 0) || (col_s >= GRID_S);
        off_grid_o = off_grid;
        cell_o     = off_grid ? '0 : cell_idx(row_s[3:0], col_s[3:0]);
        ray_end_o  = off_grid || (step_q == 4'(RANGE));
        last_dir_o = (dir_q == DIR_RIGHT);
    end

endmodule

// File: rtl/bomb_blast_engine.sv
// Bomb blast engine: per tick, snapshots the arena and bomb maps, ages every
// fuse one cell per cycle, then detonates expired bombs lowest index first,
// walking cross-shaped flame with flame_walker, and publishes the maps in one
// commit cycle. Optional macro CHAIN_REACTION_EN makes flame detonate live
// bombs it reaches within the same tick; without it they keep their fuse.
module bomb_blast_engine
    import bomb_pkg::*;
#(
    parameter int RANGE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [2*NCELL-1:0] arena_in,
    input  logic [2*NCELL-1:0] bomb_in,
    input  logic [3:0]         pa_x,
    input  logic [3:0]         pa_y,
    input  logic [3:0]         pb_x,
    input  logic [3:0]         pb_y,
    output logic [2*NCELL-1:0] bomb_out,
    output logic [NCELL-1:0]   fire_out,
    output logic               pa_dead,
    output logic               pb_dead,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               walking_q, walking_d;
    logic [2*NCELL-1:0] arena_q, arena_d;
    logic [2*NCELL-1:0] bombs_q, bombs_d;
    logic [NCELL-1:0]   det_q, det_d;
    logic [NCELL-1:0]   fire_nx_q, fire_nx_d;
    logic [2*NCELL-1:0] bomb_out_q, bomb_out_d;
    logic [NCELL-1:0]   fire_out_q, fire_out_d;
    logic               pa_dead_q, pa_dead_d;
    logic               pb_dead_q, pb_dead_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   pick;
    logic [1:0]         cur_fuse;
    logic               ray_stop;
    logic               walk_load, walk_advance, walk_turn;
    logic [IDX_W-1:0]   walk_cell;
    logic               walk_off_grid, walk_ray_end, walk_last_dir;

    flame_walker #(.RANGE(RANGE)) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (walk_load),
        .row_i      (4'(pick / IDX_W'(GRID))),
        .col_i      (4'(pick % IDX_W'(GRID))),
        .advance_i  (walk_advance),
        .turn_i     (walk_turn),
        .cell_o     (walk_cell),
        .off_grid_o (walk_off_grid),
        .ray_end_o  (walk_ray_end),
        .last_dir_o (walk_last_dir)
    );

    // Lowest pending detonation; det ordering fixes which bomb a chain reaches first.
    always_comb begin
        pick = '0;
        for (int i = NCELL - 1; i >= 0; i--) begin
            if (det_q[i]) pick = IDX_W'(i);
        end
    end

    // Scanner next state: snapshot, per-cell decay, flame walk, single-cycle publish.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        walking_d    = walking_q;
        arena_d      = arena_q;
        bombs_d      = bombs_q;
        det_d        = det_q;
        fire_nx_d    = fire_nx_q;
        bomb_out_d   = bomb_out_q;
        fire_out_d   = fire_out_q;
        pa_dead_d    = pa_dead_q;
        pb_dead_d    = pb_dead_q;
        done_d       = 1'b0;
        cur_fuse     = FUSE_NONE;
        ray_stop     = 1'b0;
        walk_load    = 1'b0;
        walk_advance = 1'b0;
        walk_turn    = 1'b0;

        if (tick && (state_q != IDLE)) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    arena_d   = arena_in;
                    bombs_d   = bomb_in;
                    pending_d = 1'b0;
                    fire_nx_d = '0;
                    det_d     = '0;
                    cnt_d     = '0;
                    state_d   = DECAY;
                end
            end
            DECAY: begin
                cur_fuse = bombs_q[2*int'(cnt_q) +: 2];
                if (cur_fuse != FUSE_NONE) begin
                    bombs_d[2*int'(cnt_q) +: 2] = cur_fuse - 2'd1;
                    if (cur_fuse == 2'd1) det_d[cnt_q] = 1'b1;
                end
                if (cnt_q == IDX_W'(NCELL - 1)) begin
                    cnt_d     = '0;
                    walking_d = 1'b0;
                    state_d   = BLAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLAST: begin
                if (!walking_q) begin
                    if (det_q == '0) begin
                        state_d = COMMIT;
                    end else begin
                        det_d[pick]     = 1'b0;
                        fire_nx_d[pick] = 1'b1;
                        walk_load       = 1'b1;
                        walking_d       = 1'b1;
                    end
                end else begin
                    ray_stop = walk_ray_end;
                    if (!walk_off_grid) begin
                        if (arena_q[2*int'(walk_cell) +: 2] == CELL_WALL) begin
                            ray_stop = 1'b1;
                        end else begin
                            fire_nx_d[walk_cell] = 1'b1;
                            if (bombs_q[2*int'(walk_cell) +: 2] != FUSE_NONE) begin
                                ray_stop = 1'b1;
`ifdef CHAIN_REACTION_EN
                                bombs_d[2*int'(walk_cell) +: 2] = FUSE_NONE;
                                det_d[walk_cell]                = 1'b1;
`else
                                // The live bomb keeps its fuse; the ray simply ends here.
`endif
                            end
                        end
                    end
                    if (!ray_stop)          walk_advance = 1'b1;
                    else if (walk_last_dir) walking_d    = 1'b0;
                    else                    walk_turn    = 1'b1;
                end
            end
            COMMIT: begin
                bomb_out_d = bombs_q;
                fire_out_d = fire_nx_q;
                if ((pa_x < 4'(GRID)) && (pa_y < 4'(GRID)))
                    pa_dead_d = pa_dead_q | fire_nx_q[cell_idx(pa_x, pa_y)];
                if ((pb_x < 4'(GRID)) && (pb_y < 4'(GRID)))
                    pb_dead_d = pb_dead_q | fire_nx_q[cell_idx(pb_x, pb_y)];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and map registers; reset aborts any scan in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the snapshot maps are ordinary flops, not a RAM, so they share the async reset and an aborted scan leaves nothing behind.
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            walking_q  <= 1'b0;
            arena_q    <= '0;
            bombs_q    <= '0;
            det_q      <= '0;
            fire_nx_q  <= '0;
            bomb_out_q <= '0;
            fire_out_q <= '0;
            pa_dead_q  <= 1'b0;
            pb_dead_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            walking_q  <= walking_d;
            arena_q    <= arena_d;
            bombs_q    <= bombs_d;
            det_q      <= det_d;
            fire_nx_q  <= fire_nx_d;
            bomb_out_q <= bomb_out_d;
            fire_out_q <= fire_out_d;
            pa_dead_q  <= pa_dead_d;
            pb_dead_q  <= pb_dead_d;
            done_q     <= done_d;
        end
    end

    assign bomb_out = bomb_out_q;
    assign fire_out = fire_out_q;
    assign pa_dead  = pa_dead_q;
    assign pb_dead  = pb_dead_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bomb_blast_engine.sv
// Self-checking bench for bomb_blast_engine: directed scenarios plus random
// arenas, compared against a row/col reference model of ageing and flame.
module tb_bomb_blast_engine;
    import bomb_pkg::*;

    localparam int RANGE = 2;
    localparam int NC    = GRID * GRID;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            tick  = 1'b0;
    logic [2*NC-1:0] arena_in, bomb_in, bomb_out;
    logic [NC-1:0]   fire_out;
    logic [3:0]      pa_x, pa_y, pb_x, pb_y;
    logic            pa_dead, pb_dead, busy, done;

    bomb_blast_engine #(.RANGE(RANGE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .arena_in (arena_in),
        .bomb_in  (bomb_in),
        .pa_x     (pa_x),
        .pa_y     (pa_y),
        .pb_x     (pb_x),
        .pb_y     (pb_y),
        .bomb_out (bomb_out),
        .fire_out (fire_out),
        .pa_dead  (pa_dead),
        .pb_dead  (pb_dead),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_arena[NC];
    int m_bin[NC];
    int e_bomb[NC];
    bit e_fire[NC];
    bit e_pa, e_pb;
    int pa_r, pa_c, pb_r, pb_c;

    task automatic check(input string tag, input logic [2*NC-1:0] got, input logic [2*NC-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_maps();
        for (int c = 0; c < NC; c++) begin
            m_arena[c] = 0;
            m_bin[c]   = 0;
        end
    endtask

    task automatic set_players(input int ar, input int ac, input int br, input int bc);
        pa_r = ar; pa_c = ac; pb_r = br; pb_c = bc;
        m_arena[ar*GRID+ac] = int'(CELL_PA);
        m_arena[br*GRID+bc] = int'(CELL_PB);
    endtask

    task automatic apply_inputs();
        for (int c = 0; c < NC; c++) begin
            arena_in[2*c +: 2] = 2'(m_arena[c]);
            bomb_in[2*c +: 2]  = 2'(m_bin[c]);
        end
        pa_x = 4'(pa_r); pa_y = 4'(pa_c);
        pb_x = 4'(pb_r); pb_y = 4'(pb_c);
    endtask

    // Reference: age every fuse, then detonate lowest index first with cross-shaped rays.
    task automatic model_tick();
        int b[NC];
        bit det[NC];
        bit f[NC];
        int dr[4];
        int dc[4];
        dr = '{-1, 1, 0, 0};
        dc = '{0, 0, -1, 1};
        for (int c = 0; c < NC; c++) begin
            b[c]   = (m_bin[c] > 0) ? m_bin[c] - 1 : 0;
            det[c] = (m_bin[c] == 1);
            f[c]   = 1'b0;
        end
        for (int g = 0; g < NC; g++) begin
            int o;
            o = -1;
            for (int c = NC - 1; c >= 0; c--) if (det[c]) o = c;
            if (o < 0) break;
            det[o] = 1'b0;
            f[o]   = 1'b1;
            for (int d = 0; d < 4; d++) begin
                for (int s = 1; s <= RANGE; s++) begin
                    int r, cc, n;
                    r  = o / GRID + dr[d] * s;
                    cc = o % GRID + dc[d] * s;
                    if (r < 0 || r >= GRID || cc < 0 || cc >= GRID) break;
                    n = r * GRID + cc;
                    if (m_arena[n] == int'(CELL_WALL)) break;
                    f[n] = 1'b1;
                    if (b[n] != 0) begin
`ifdef CHAIN_REACTION_EN
                        b[n]   = 0;
                        det[n] = 1'b1;
`endif
                        break;
                    end
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            e_bomb[c] = b[c];
            e_fire[c] = f[c];
        end
        e_pa = e_pa | f[pa_r*GRID+pa_c];
        e_pb = e_pb | f[pb_r*GRID+pb_c];
    endtask

    task automatic compare_outputs(input string tag);
        logic [2*NC-1:0] eb;
        logic [NC-1:0]   ef;
        for (int c = 0; c < NC; c++) begin
            eb[2*c +: 2] = 2'(e_bomb[c]);
            ef[c]        = e_fire[c];
        end
        check({tag, "_bomb"}, bomb_out, eb);
        check({tag, "_fire"}, fire_out, ef);
        check({tag, "_pa"}, pa_dead, e_pa);
        check({tag, "_pb"}, pb_dead, e_pb);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_scan(input string tag);
        bit seen;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        model_tick();
        compare_outputs(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        tick  = 1'b0;
        #1;
        check({tag, "_bomb"}, bomb_out, '0);
        check({tag, "_fire"}, fire_out, '0);
        check({tag, "_pa"}, pa_dead, 1'b0);
        check({tag, "_pb"}, pb_dead, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e_pa = 1'b0;
        e_pb = 1'b0;
        for (int c = 0; c < NC; c++) begin
            e_bomb[c] = 0;
            e_fire[c] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NC-1:0] exp_f;
        int            n_done;

        clear_maps();
        set_players(0, 9, 9, 9);
        apply_inputs();
        #2;
        apply_reset("reset");

        // Bomb with a fresh fuse in an open arena: 3 -> 2 -> 1 -> blast.
        clear_maps();
        set_players(0, 9, 9, 9);
        m_bin[44] = int'(FUSE_NEW);
        apply_inputs();
        run_scan("age1");
        check("age1_b44", bomb_out[88 +: 2], 2'd2);
        for (int c = 0; c < NC; c++) m_bin[c] = e_bomb[c];
        apply_inputs();
        run_scan("age2");
        check("age2_b44", bomb_out[88 +: 2], 2'd1);
        for (int c = 0; c < NC; c++) m_bin[c] = e_bomb[c];
        apply_inputs();
        run_scan("age3");
        exp_f = '0;
        exp_f[24] = 1'b1; exp_f[34] = 1'b1; exp_f[44] = 1'b1; exp_f[54] = 1'b1; exp_f[64] = 1'b1;
        exp_f[42] = 1'b1; exp_f[43] = 1'b1; exp_f[45] = 1'b1; exp_f[46] = 1'b1;
        check("age3_cross", fire_out, exp_f);
        check("age3_b44", bomb_out[88 +: 2], 2'd0);

        // Corner bomb next to a wall: no flame on or past the wall, no wrap.
        clear_maps();
        set_players(9, 0, 9, 9);
        m_bin[0]   = 1;
        m_arena[1] = int'(CELL_WALL);
        apply_inputs();
        run_scan("corner");
        exp_f = '0;
        exp_f[0] = 1'b1; exp_f[10] = 1'b1; exp_f[20] = 1'b1;
        check("corner_exact", fire_out, exp_f);

        // Player A inside the flame, B outside; the flag is sticky.
        clear_maps();
        set_players(5, 7, 9, 9);
        m_bin[55] = 1;
        apply_inputs();
        run_scan("kill");
        check("kill_pa_set", pa_dead, 1'b1);
        check("kill_pb_clear", pb_dead, 1'b0);
        for (int c = 0; c < NC; c++) m_bin[c] = 0;
        apply_inputs();
        run_scan("hold1");
        run_scan("hold2");
        check("hold_pa_sticky", pa_dead, 1'b1);
        check("hold_fire_off", fire_out, '0);

        apply_reset("reset2");

        // A detonating bomb's ray reaches a second, live bomb.
        clear_maps();
        set_players(9, 0, 9, 9);
        m_bin[33] = 1;
        m_bin[35] = 2;
        apply_inputs();
        run_scan("chain");
        check("chain_b35_burn", fire_out[35], 1'b1);
`ifdef CHAIN_REACTION_EN
        check("chain_b35_val", bomb_out[70 +: 2], 2'd0);
        check("chain_b37_fire", fire_out[37], 1'b1);
`else
        check("chain_b35_val", bomb_out[70 +: 2], 2'd1);
        check("chain_b37_fire", fire_out[37], 1'b0);
`endif

        // Ticks 5 cycles apart, then a third during DECAY: exactly two scans.
        clear_maps();
        set_players(0, 0, 9, 0);
        m_bin[12] = 1;
        m_bin[77] = 1;
        apply_inputs();
        n_done = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick = (cyc == 0 || cyc == 5 || cyc == 20);
            @(negedge clk);
            if (done) n_done++;
        end
        tick = 1'b0;
        check("pend_done_count", 32'(n_done), 32'd2);
        model_tick();
        model_tick();
        compare_outputs("pend");

        // Random arenas with fed-back bomb maps and fresh placements.
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < NC; c++) begin
                m_arena[c] = ($urandom_range(0, 99) < 15) ? int'(CELL_WALL) : int'(CELL_EMPTY);
                m_bin[c]   = e_bomb[c];
                if ($urandom_range(0, 99) < 10) m_bin[c] = int'($urandom_range(1, 3));
            end
            set_players(int'($urandom_range(0, GRID-1)), int'($urandom_range(0, GRID-1)),
                        int'($urandom_range(0, GRID-1)), int'($urandom_range(0, GRID-1)));
            for (int c = 0; c < NC; c++) if (m_arena[c] == int'(CELL_WALL)) m_bin[c] = 0;
            apply_inputs();
            run_scan($sformatf("rnd%0d", it));
            if (it % 6 == 5) apply_reset($sformatf("rnd_rst%0d", it));
        end

        // Reset asserted in the middle of BLAST clears every output at once.
        clear_maps();
        set_players(0, 0, 9, 9);
        m_bin[0]  = 1;
        m_bin[22] = 1;
        m_bin[47] = 1;
        m_bin[63] = 1;
        m_bin[99] = 1;
        apply_inputs();
        run_scan("preabort");
        m_bin[5]  = 1;
        m_bin[50] = 1;
        m_bin[88] = 1;
        m_bin[31] = 1;
        apply_inputs();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int cyc = 0; cyc < 110; cyc++) @(negedge clk);
        check("abort_busy", busy, 1'b1);
        apply_reset("abort");
        run_scan("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
